// File: rtl/dffrn_cell_checker.sv
// rtl/dffrn_cell_checker.sv - stimulus/response checker for the CLKN/RN D flop cell
// Drives D/RN/CLKN through reset and capture phases, compares Q/QN against the applied data.
module dffrn_cell_checker #(
    parameter int         NUM_VEC   = 64,
    parameter int         RST_EVERY = 16,
    parameter int         SETTLE    = 2,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         ERR_W     = 8,
    parameter int         VEC_W     = 16
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             START,
    output logic             DUT_D,
    output logic             DUT_RN,
    output logic             DUT_CLKN,
    input  logic             DUT_Q,
    input  logic             DUT_QN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [VEC_W-1:0] VEC_CNT
);

    localparam int TMR_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RPULSE,
        S_RCHECK,
        S_RREL,
        S_SETUP,
        S_EDGE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [TMR_W-1:0] tmr_q;
    logic [7:0]       lfsr_q;
    logic             exp_q;
    logic [VEC_W-1:0] seg_q;
    logic [VEC_W-1:0] vec_q;
    logic [ERR_W-1:0] err_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             dut_d_q;
    logic             dut_rn_q;
    logic             dut_clkn_q;

    logic [7:0]       lfsr_d;
    logic [VEC_W-1:0] vec_d;
    logic [VEC_W-1:0] seg_d;
    logic [ERR_W-1:0] err_d;
    logic             chk_bad;
    logic             tmr_done;
    logic             last_vec;
    logic             pulse_due;

    always_comb begin
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        vec_d     = vec_q + 1'b1;
        seg_d     = seg_q + 1'b1;
        tmr_done  = (tmr_q == '0);
        last_vec  = (vec_d == VEC_W'(NUM_VEC));
        pulse_due = (RST_EVERY != 0) && (seg_d == VEC_W'(RST_EVERY));
        // Reset check expects Q=0/QN=1; capture check expects Q=exp/QN=~exp.
        if (state_q == S_RCHECK) begin
            chk_bad = DUT_Q | ~DUT_QN;
        end else begin
            chk_bad = (DUT_Q != exp_q) | (DUT_QN == exp_q);
        end
        err_d = err_q;
        if (chk_bad && !(&err_q)) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            lfsr_q     <= LFSR_SEED;
            exp_q      <= 1'b0;
            seg_q      <= '0;
            vec_q      <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            dut_d_q    <= 1'b0;
            dut_rn_q   <= 1'b0;
            dut_clkn_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        err_q      <= '0;
                        vec_q      <= '0;
                        seg_q      <= '0;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        lfsr_q     <= LFSR_SEED;
                        busy_q     <= 1'b1;
                        dut_rn_q   <= 1'b0;
                        dut_clkn_q <= 1'b0;
                        tmr_q      <= TMR_LOAD;
                        state_q    <= S_RPULSE;
                    end
                end
                S_RPULSE: begin
                    if (tmr_done) begin
                        state_q <= S_RCHECK;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                S_RCHECK: begin
                    err_q    <= err_d;
                    dut_rn_q <= 1'b1;
                    tmr_q    <= TMR_LOAD;
                    state_q  <= S_RREL;
                end
                S_RREL: begin
                    if (tmr_done) begin
                        dut_d_q <= lfsr_q[7];
                        tmr_q   <= TMR_LOAD;
                        state_q <= S_SETUP;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                S_SETUP: begin
                    if (tmr_done) begin
                        dut_clkn_q <= 1'b1;
                        exp_q      <= dut_d_q;
                        tmr_q      <= TMR_LOAD;
                        state_q    <= S_EDGE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                S_EDGE: begin
                    if (tmr_done) begin
                        state_q <= S_CHECK;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                S_CHECK: begin
                    err_q      <= err_d;
                    vec_q      <= vec_d;
                    lfsr_q     <= lfsr_d;
                    dut_clkn_q <= 1'b0;
                    tmr_q      <= TMR_LOAD;
                    // Finishing the run wins over a reset pulse due on the same vector.
                    if (last_vec) begin
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        pass_q   <= (err_d == '0);
                        dut_rn_q <= 1'b0;
                        state_q  <= S_DONE;
                    end else if (pulse_due) begin
                        seg_q    <= '0;
                        dut_rn_q <= 1'b0;
                        state_q  <= S_RPULSE;
                    end else begin
                        seg_q   <= seg_d;
                        dut_d_q <= lfsr_d[7];
                        state_q <= S_SETUP;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign DUT_D    = dut_d_q;
    assign DUT_RN   = dut_rn_q;
    assign DUT_CLKN = dut_clkn_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign PASS     = pass_q;
    assign ERR_CNT  = err_q;
    assign VEC_CNT  = vec_q;

endmodule
